mram_access_arbiter: RTL and testbench
======================================

Name: mram_access_arbiter

Overview:
Two-port arbiter and bus sequencer for the external 16-bit MRAM. It accepts parallel word requests from two requesters and grants them round-robin. Port 0 is the serial-to-parallel host path; port 1 is the test/scrub engine. For each granted request it drives one timed read or write cycle on the MRAM pins: address, data bus, chip_en, write_en, out_en and the byte enables. It sits between the serial front end and the MRAM pin drivers, in place of the direct read_write_sel strobing.

Parameters:
ADDR_W, 20, MRAM address width
DATA_W, 16, MRAM data width
WR_CYCLES, 4, clocks write_en is held low per write (>=1)
RD_CYCLES, 4, clocks out_en is held low before read data is sampled (>=1)
TURN_CYCLES, 1, idle clocks after each access, with chip_en high (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req0 / req1  in  1  access request; held high until the matching gnt
we0 / we1  in  1  1 = write, 0 = read
addr0 / addr1  in  ADDR_W  word address
wdata0 / wdata1  in  DATA_W  write data
be0 / be1  in  2  byte enables; bit0 = lower byte, bit1 = upper byte
gnt0 / gnt1  out  1  one-cycle pulse when the request is latched
done0 / done1  out  1  one-cycle pulse when the access completes
rdata  out  DATA_W  read data, valid from the done pulse until the next read completes
busy  out  1  high in every state except IDLE
addr_out  out  ADDR_W  MRAM address pins
dq_out  out  DATA_W  MRAM write data
dq_oe  out  1  tristate enable for dq_out
dq_in  in  DATA_W  MRAM read data pins
chip_en, write_en, out_en, lower_byte_en, upper_byte_en  out  1 each  MRAM strobes, all active-low

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - chip_en, write_en, out_en, lower_byte_en and upper_byte_en = 1.
  - dq_oe = 0; gnt*, done*, busy = 0; addr_out, dq_out, rdata = 0.
  - State = IDLE; round-robin pointer last = 1, so port 0 wins first.
  - An interrupted access never issues its done pulse.
- States: IDLE -> SETUP -> ACCESS -> TURN -> IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - If exactly one req is high, select that port.
  - If both are high, select the port that is not `last`, then set last = selected port.
  - On the selecting edge:
    - Latch we, addr, wdata and be into internal registers.
    - Pulse gnt of the selected port for exactly one cycle.
    - Move to SETUP.
  - A requester may change or drop its fields after seeing gnt.
- SETUP (1 cycle):
  - addr_out = latched address; chip_en = 0.
  - lower_byte_en = ~be[0]; upper_byte_en = ~be[1].
  - For a write: dq_out = latched data, dq_oe = 1.
  - write_en and out_en stay 1.
- ACCESS:
  - Write: write_en = 0 for WR_CYCLES cycles.
  - Read: out_en = 0 for RD_CYCLES cycles; rdata captures dq_in on the edge that leaves ACCESS.
  - Cycle count comes from a down-counter loaded on SETUP entry.
- TURN (TURN_CYCLES cycles):
  - chip_en, write_en, out_en and both byte enables = 1.
  - addr_out and dq_out held, for hold time.
  - dq_oe stays 1 through TURN after a write and drops to 0 on IDLE entry.
  - The done pulse of the owning port is asserted in the first TURN cycle.
- Latency:
  - req sampled at edge E -> gnt high in cycle E+1 (SETUP).
  - done high in cycle E+2+N, where N = WR_CYCLES or RD_CYCLES.
  - IDLE again at E+2+N+TURN_CYCLES.
  - Back-to-back throughput: one access per 2+N+TURN_CYCLES clocks (7 with defaults); a new grant is only issued from IDLE.
- Boundaries:
  - be = 00: the full cycle still runs with both byte enables high, and done still pulses.
  - addr = all-ones is legal; there is no address wrap logic.
  - A request arriving during busy waits in place, with no loss or reordering.
  - One port requesting continuously while the other is idle is granted back-to-back.
- Invariants:
  - write_en and out_en are never low in the same cycle.
  - chip_en is never low outside SETUP and ACCESS.
  - Exactly one gnt is asserted per access.

Test Plan:
- Reset then idle: all strobes 1, dq_oe 0, busy 0 for 10 cycles with no req; assert rst mid-ACCESS -> strobes go 1 asynchronously, no done.
- Port 0 write addr 0x00000, wdata 0x5555, be 11 -> gnt0 one cycle after req; write_en low exactly 4 cycles; dq_out 0x5555 with dq_oe 1 from SETUP through TURN; done0 at req+6; busy clears at req+7.
- Port 1 read addr 0xFFFFF, be 01, dq_in model returns 0xA5C3 -> out_en low 4 cycles, lower_byte_en 0, upper_byte_en 1, rdata 0xA5C3 coincident with done1, write_en stays 1.
- req0 and req1 high together, both reads, held continuously -> grants alternate 0,1,0,1 with 7-cycle spacing.
- Only req1 held for 3 accesses -> gnt1 at cycles +1, +8, +15, with no gnt0.
- be = 00 write -> both byte enables stay 1, write_en still low 4 cycles, done pulses; pin monitor confirms write_en and out_en are never low together.

Source files
------------

// File: rtl/mram_access_arbiter.sv
// Round-robin two-port arbiter that sequences one timed read or write cycle
// on the external 16-bit MRAM pins per granted request.
module mram_access_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WR_CYCLES   = 4,
  parameter int RD_CYCLES   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        be0,
  input  logic [1:0]        be1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_in,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);

  localparam int MAX_RW = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int MAXC   = (MAX_RW > TURN_CYCLES) ? MAX_RW : TURN_CYCLES;
  localparam int CNT_W  = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;

  state_t           state, state_nx;
  logic             last;
  logic             owner;
  logic             we_q;
  logic [1:0]       be_q;
  logic [CNT_W-1:0] cnt;
  logic             pick0, pick1;
  logic             sel_we;

  assign busy   = (state != IDLE);
  assign sel_we = pick1 ? we1 : we0;

  // Strobes are decoded straight from the state register so an async reset
  // releases every pin immediately.
  always_comb begin
    state_nx      = state;
    pick0         = 1'b0;
    pick1         = 1'b0;
    chip_en       = 1'b1;
    write_en      = 1'b1;
    out_en        = 1'b1;
    lower_byte_en = 1'b1;
    upper_byte_en = 1'b1;
    case (state)
      IDLE: begin
        pick0 = req0 && (!req1 || last);
        pick1 = req1 && !pick0;
        if (pick0 || pick1) state_nx = SETUP;
      end
      SETUP: begin
        chip_en       = 1'b0;
        lower_byte_en = ~be_q[0];
        upper_byte_en = ~be_q[1];
        state_nx      = ACCESS;
      end
      ACCESS: begin
        chip_en       = 1'b0;
        lower_byte_en = ~be_q[0];
        upper_byte_en = ~be_q[1];
        write_en      = ~we_q;
        out_en        = we_q;
        if (cnt == '0) state_nx = TURN;
      end
      TURN: begin
        if (cnt == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      cnt      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      addr_out <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      rdata    <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick0 || pick1) begin
            owner    <= pick1;
            gnt0     <= pick0;
            gnt1     <= pick1;
            // Pointer only moves when both ports actually contended.
            if (req0 && req1) last <= pick1;
            we_q     <= sel_we;
            be_q     <= pick1 ? be1 : be0;
            addr_out <= pick1 ? addr1 : addr0;
            if (sel_we) begin
              dq_out <= pick1 ? wdata1 : wdata0;
              dq_oe  <= 1'b1;
            end
            cnt <= sel_we ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(TURN_CYCLES - 1);
            done0 <= ~owner;
            done1 <= owner;
            if (!we_q) rdata <= dq_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        TURN: begin
          if (cnt == '0) dq_oe <= 1'b0;
          else           cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mram_access_arbiter.sv
// Directed bench for mram_access_arbiter: each task drives one scenario and
// checks cycle-accurate pin behaviour against hand-computed values.
module tb_mram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [19:0] addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic [1:0]  be0 = 0, be1 = 0;
  logic        gnt0, gnt1, done0, done1, busy, dq_oe;
  logic [15:0] rdata, dq_out, dq_in;
  logic [19:0] addr_out;
  logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
  logic [15:0] rd_model = 16'hA5C3;

  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap_cnt = 0;
  int ce_bad_cnt = 0;

  always #5 clk = ~clk;

  // MRAM model drives read data only while out_en is asserted.
  assign dq_in = (!out_en) ? rd_model : 16'h0000;

  mram_access_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .addr_out(addr_out), .dq_out(dq_out),
    .dq_oe(dq_oe), .dq_in(dq_in),
    .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
    .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (!write_en && !out_en) overlap_cnt++;
      if (!chip_en && !busy) ce_bad_cnt++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin @(negedge clk); n++; end
    total_cnt++;
    if (busy) $display("FAIL wait_idle: busy still 1 after 30 cycles");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (chip_en !== 1 || write_en !== 1 || out_en !== 1 || lower_byte_en !== 1 ||
          upper_byte_en !== 1 || dq_oe !== 0 || busy !== 0 || gnt0 !== 0 || gnt1 !== 0)
        bad++;
    end
    chk("reset_idle_bad_cycles", bad, 0);
    chk("reset_addr_out", addr_out, 0);
    chk("reset_rdata", rdata, 0);
  endtask

  task automatic test_write();
    int gnt_at = -1, done_at = -1, idle_at = -1, wl = 0, dq_bad = 0, g0 = 0, g1 = 0;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 20'h00000; wdata0 = 16'h5555; be0 = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt0) begin g0++; if (gnt_at < 0) gnt_at = i; req0 = 0; end
      if (gnt1) g1++;
      if (!write_en) wl++;
      if (done0 && done_at < 0) done_at = i;
      if (!busy && idle_at < 0) idle_at = i;
      if (i <= 6 && (dq_oe !== 1 || dq_out !== 16'h5555)) dq_bad++;
      if (i == 7) chk("write_dq_oe_idle", dq_oe, 0);
    end
    chk("write_gnt_at", gnt_at, 1);
    chk("write_gnt0_count", g0, 1);
    chk("write_gnt1_count", g1, 0);
    chk("write_we_low_cycles", wl, 4);
    chk("write_dq_drive_bad", dq_bad, 0);
    chk("write_done_at", done_at, 6);
    chk("write_idle_at", idle_at, 7);
  endtask

  task automatic test_read();
    int gnt_at = -1, done_at = -1, ol = 0, wl = 0, d0 = 0;
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 20'hFFFFF; be1 = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (gnt1) begin if (gnt_at < 0) gnt_at = i; req1 = 0; end
      if (!out_en) ol++;
      if (!write_en) wl++;
      if (done0) d0++;
      if (i == 1) chk("read_addr_out", addr_out, 20'hFFFFF);
      if (i == 2) begin
        chk("read_lower_be", lower_byte_en, 0);
        chk("read_upper_be", upper_byte_en, 1);
      end
      if (done1 && done_at < 0) begin
        done_at = i;
        chk("read_rdata_at_done", rdata, 16'hA5C3);
      end
    end
    chk("read_gnt_at", gnt_at, 1);
    chk("read_oe_low_cycles", ol, 4);
    chk("read_we_low_cycles", wl, 0);
    chk("read_done_at", done_at, 6);
    chk("read_no_done0", d0, 0);
  endtask

  task automatic test_alternate();
    int ports[4], times[4], n = 0;
    @(negedge clk);
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 20'h00010; addr1 = 20'h00020;
    be0 = 2'b11; be1 = 2'b11;
    for (int i = 1; i <= 30 && n < 4; i++) begin
      @(negedge clk);
      if (gnt0 && gnt1) chk("alt_dual_gnt", 1, 0);
      if (gnt0 || gnt1) begin
        ports[n] = gnt1 ? 1 : 0;
        times[n] = i;
        n++;
      end
    end
    req0 = 0; req1 = 0;
    chk("alt_grant_count", n, 4);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("alt_port_%0d", k), ports[k], k % 2);
      chk($sformatf("alt_time_%0d", k), times[k], 1 + 7 * k);
    end
    wait_idle();
  endtask

  task automatic test_single_port();
    int times[3], n = 0, g0 = 0;
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 20'h00ABC; be1 = 2'b10;
    for (int i = 1; i <= 20 && n < 3; i++) begin
      @(negedge clk);
      if (gnt0) g0++;
      if (gnt1) begin times[n] = i; n++; end
    end
    req1 = 0;
    chk("single_grant_count", n, 3);
    for (int k = 0; k < n; k++) chk($sformatf("single_time_%0d", k), times[k], 1 + 7 * k);
    chk("single_no_gnt0", g0, 0);
    wait_idle();
  endtask

  task automatic test_be_zero();
    int wl = 0, be_low = 0, done_at = -1;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 20'h12345; wdata0 = 16'h0F0F; be0 = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (gnt0) req0 = 0;
      if (!write_en) wl++;
      if (!lower_byte_en || !upper_byte_en) be_low++;
      if (done0 && done_at < 0) done_at = i;
    end
    chk("be0_byte_en_low", be_low, 0);
    chk("be0_we_low_cycles", wl, 4);
    chk("be0_done_at", done_at, 6);
    chk("monitor_we_oe_overlap", overlap_cnt, 0);
    chk("monitor_ce_outside_access", ce_bad_cnt, 0);
  endtask

  task automatic test_reset_mid_access();
    int d = 0;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 20'h00777; wdata0 = 16'hBEEF; be0 = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (gnt0) req0 = 0;
    end
    chk("mid_we_low_before_rst", write_en, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", write_en, 1);
    chk("mid_rst_ce", chip_en, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dq_oe", dq_oe, 0);
    chk("mid_rst_addr_out", addr_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1) d++;
    end
    chk("mid_rst_no_done", d, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_single_port();
    test_be_zero();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
